// File: rtl/sauria_fix_pkg.sv
// Shared types and constants for the SAURIA demo SoC result-capture fixture:
// FSM state encoding, exit codes and per-matrix geometry.
package sauria_fix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } fix_state_e;

  localparam logic [31:0] EXIT_OK         = 32'd0;
  localparam logic [31:0] EXIT_BOOT_UNSUP = 32'd1;
  localparam logic [31:0] EXIT_PREL_UNSUP = 32'd2;

  localparam int LINES_PER_MAT = 64;
  localparam int WORDS_PER_MAT = 256;

  localparam logic [1:0] BOOT_DEFAULT = 2'd0;
  localparam logic [1:0] BOOT_SDCARD  = 2'd1;
  localparam logic [1:0] PREL_UNSUP   = 2'd3;

endpackage

// File: rtl/sauria_fix_sram.sv
// Result SRAM: one write port, one synchronous read port, read-first on
// same-line collisions. Read data register resets to zero, the array does not.
module sauria_fix_sram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto a RAM macro; only the read register is reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Read sees the pre-edge array value, which gives read-first on collisions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/sauria_demo_soc_fixture.sv
// Result-capture fixture: run-command decode, word-stream packing into 128-bit
// lines, end-of-computation reporting. Define SAURIA_FIX_MEM_INIT_EN for a zero-fill sweep after reset.
module sauria_demo_soc_fixture
  import sauria_fix_pkg::*;
#(
  parameter int SelectedCfg    = 0,
  parameter int UseDramSys     = 0,
  parameter int NUM_MATS       = 8,
  parameter int ROWS           = 16,
  parameter int COLS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [1:0]                               boot_mode_i,
  input  logic [1:0]                               preload_mode_i,
  input  logic                                     start_i,
  input  logic                                     res_valid_i,
  input  logic [31:0]                              res_data_i,
  output logic                                     res_ready_o,
  input  logic                                     rd_en_i,
  input  logic [$clog2(NUM_MATS*LINES_PER_MAT)-1:0] rd_addr_i,
  output logic [32*WORDS_PER_LINE-1:0]             rd_data_o,
  output logic                                     eoc_o,
  output logic [31:0]                              exit_code_o
);

  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int STG_W  = LINE_W - 32;
  localparam int DEPTH  = NUM_MATS * LINES_PER_MAT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TOTAL  = NUM_MATS * ROWS * COLS;
  localparam int CNT_W  = $clog2(TOTAL);
  localparam int LANE_W = $clog2(WORDS_PER_LINE);

  // Configuration indices are carried for the SoC wrapper only.
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(SelectedCfg) ^ 32'(UseDramSys);

  fix_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STG_W-1:0]    stg_q, stg_d;
  logic [31:0]         exit_q, exit_d;
  logic                run_we;
  logic                init_busy;
  logic [LANE_W-1:0]   lane;
  logic [ADDR_W-1:0]   line_idx;
  logic                sram_we;
  logic [ADDR_W-1:0]   sram_waddr;
  logic [LINE_W-1:0]   sram_wdata;

  // Row-major with whole lines per row, so the line index is simply k / WORDS_PER_LINE.
  assign lane     = cnt_q[LANE_W-1:0];
  assign line_idx = cnt_q[CNT_W-1:LANE_W];

`ifdef SAURIA_FIX_MEM_INIT_EN
  logic              init_busy_q;
  logic [ADDR_W-1:0] init_addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_busy_q <= 1'b1;
      init_addr_q <= '0;
    end else if (init_busy_q) begin
      init_addr_q <= init_addr_q + 1'b1;
      if (init_addr_q == ADDR_W'(DEPTH - 1)) init_busy_q <= 1'b0;
    end
  end
  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
      exit_q  <= EXIT_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      exit_q  <= exit_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    exit_d  = exit_q;
    run_we  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (res_valid_i) begin
          cnt_d = cnt_q + 1'b1;
          if (lane == LANE_W'(WORDS_PER_LINE - 1)) run_we = 1'b1;
          else stg_d[32*lane +: 32] = res_data_i;
          if (cnt_q == CNT_W'(TOTAL - 1)) begin
            state_d = ST_DONE;
            exit_d  = EXIT_OK;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        if (start_i && !init_busy) begin
          cnt_d  = '0;
          stg_d  = '0;
          exit_d = EXIT_OK;
          state_d = ST_RUN;
          if (boot_mode_i == BOOT_SDCARD) begin
            state_d = ST_ERROR;
            exit_d  = EXIT_BOOT_UNSUP;
          end else if (boot_mode_i == BOOT_DEFAULT && preload_mode_i == PREL_UNSUP) begin
            state_d = ST_ERROR;
            exit_d  = EXIT_PREL_UNSUP;
          end
        end
      end
    endcase
  end

  always_comb begin
    sram_we    = run_we;
    sram_waddr = line_idx;
    sram_wdata = {res_data_i, stg_q};
`ifdef SAURIA_FIX_MEM_INIT_EN
    if (init_busy_q) begin
      sram_we    = 1'b1;
      sram_waddr = init_addr_q;
      sram_wdata = '0;
    end
`endif
  end

  assign res_ready_o = (state_q == ST_RUN);
  assign eoc_o       = (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign exit_code_o = exit_q;

  sauria_fix_sram #(
    .DEPTH (DEPTH),
    .WIDTH (LINE_W),
    .AW    (ADDR_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (sram_we),
    .wr_addr_i (sram_waddr),
    .wr_data_i (sram_wdata),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_sauria_demo_soc_fixture.sv
// Directed bench for sauria_demo_soc_fixture: full runs, mode errors,
// mid-run reset and read-first collision, with hand-computed line contents.
module tb_sauria_demo_soc_fixture;

  localparam int TOTAL = 2048;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
`ifdef SAURIA_FIX_MEM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    boot_mode_i = '0;
  logic [1:0]    preload_mode_i = '0;
  logic          start_i = 1'b0;
  logic          res_valid_i = 1'b0;
  logic [31:0]   res_data_i = '0;
  logic          res_ready_o;
  logic          rd_en_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [127:0]  rd_data_o;
  logic          eoc_o;
  logic [31:0]   exit_code_o;

  int n_checks = 0;
  int n_fail   = 0;

  sauria_demo_soc_fixture dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .boot_mode_i    (boot_mode_i),
    .preload_mode_i (preload_mode_i),
    .start_i        (start_i),
    .res_valid_i    (res_valid_i),
    .res_data_i     (res_data_i),
    .res_ready_o    (res_ready_o),
    .rd_en_i        (rd_en_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .eoc_o          (eoc_o),
    .exit_code_o    (exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] base, input int k0);
    return {base + 32'(k0 + 3), base + 32'(k0 + 2), base + 32'(k0 + 1), base + 32'(k0)};
  endfunction

  task automatic wait_init();
    if (INIT_EN) repeat (DEPTH + 2) step();
  endtask

  task automatic read_line(input logic [AW-1:0] addr, output logic [127:0] data);
    rd_en_i   = 1'b1;
    rd_addr_i = addr;
    step();
    rd_en_i = 1'b0;
    data    = rd_data_o;
  endtask

  task automatic start_run(input logic [1:0] boot, input logic [1:0] prel);
    boot_mode_i    = boot;
    preload_mode_i = prel;
    start_i        = 1'b1;
    step();
    start_i        = 1'b0;
    boot_mode_i    = 2'd0;
    preload_mode_i = 2'd0;
  endtask

  // Streams TOTAL words of base+k; optional all-ones word, optional collision probe.
  task automatic stream(input logic [31:0] base, input int neg_idx, input bit probe,
                        input logic [127:0] old0);
    for (int k = 0; k < TOTAL; k++) begin
      res_valid_i = 1'b1;
      res_data_i  = (k == neg_idx) ? 32'hFFFF_FFFF : base + 32'(k);
      if (probe && k == 3) begin
        rd_en_i   = 1'b1;
        rd_addr_i = '0;
      end
      if (probe && k == 5) rd_en_i = 1'b0;
      if (probe && k == 10) begin
        start_i     = 1'b1;
        boot_mode_i = 2'd1;
      end
      if (k == TOTAL - 1) check("eoc_before_last", 128'(eoc_o), 128'(0));
      step();
      start_i     = 1'b0;
      boot_mode_i = 2'd0;
      if (probe && k == 3) check("rd_first_old", rd_data_o, old0);
      if (probe && k == 4) check("rd_after_write", rd_data_o, line_of(base, 0));
    end
    res_valid_i = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d;

    step();
    step();
    check("rst_ready", 128'(res_ready_o), 128'(0));
    check("rst_eoc", 128'(eoc_o), 128'(0));
    check("rst_exit", 128'(exit_code_o), 128'(0));
    check("rst_rdata", rd_data_o, 128'(0));
    rst_i = 1'b0;

    if (INIT_EN) begin
      step();
      start_run(2'd0, 2'd0);
      check("sweep_start_ignored", 128'(res_ready_o), 128'(0));
      wait_init();
      read_line(9'd0, d);
      check("sweep_line0", d, 128'(0));
      read_line(9'd511, d);
      check("sweep_line511", d, 128'(0));
    end

    // Run A: boot 0 / preload 0, value k at index k.
    start_run(2'd0, 2'd0);
    check("a_ready", 128'(res_ready_o), 128'(1));
    check("a_eoc_low", 128'(eoc_o), 128'(0));
    stream(32'd0, -1, 1'b0, 128'(0));
    check("a_eoc", 128'(eoc_o), 128'(1));
    check("a_exit", 128'(exit_code_o), 128'(0));
    check("a_ready_low", 128'(res_ready_o), 128'(0));
    read_line(9'd5, d);
    check("a_line5", d, {32'd23, 32'd22, 32'd21, 32'd20});
    read_line(9'd0, d);
    check("a_line0", d, line_of(32'd0, 0));
    read_line(9'd511, d);
    check("a_line511", d, line_of(32'd0, 2044));
    rd_addr_i = 9'd5;
    step();
    check("rd_hold", rd_data_o, line_of(32'd0, 2044));

    // Run B: restart from DONE, all-ones at matrix 3 row 15 col 15.
    start_run(2'd0, 2'd2);
    check("b_eoc_cleared", 128'(eoc_o), 128'(0));
    check("b_ready", 128'(res_ready_o), 128'(1));
    stream(32'h1000, 1023, 1'b0, 128'(0));
    check("b_eoc", 128'(eoc_o), 128'(1));
    check("b_exit", 128'(exit_code_o), 128'(0));
    read_line(9'd255, d);
    check("b_line255_top", 128'(d[127:96]), 128'(32'hFFFF_FFFF));
    check("b_line255", d, {32'hFFFF_FFFF, 32'h13FE, 32'h13FD, 32'h13FC});
    read_line(9'd5, d);
    check("b_line5", d, line_of(32'h1000, 20));

    // Unsupported boot / preload modes.
    start_run(2'd1, 2'd0);
    check("sd_eoc", 128'(eoc_o), 128'(1));
    check("sd_exit", 128'(exit_code_o), 128'(1));
    check("sd_ready", 128'(res_ready_o), 128'(0));
    res_valid_i = 1'b1;
    step();
    res_valid_i = 1'b0;
    check("sd_ready_hold", 128'(res_ready_o), 128'(0));
    start_run(2'd0, 2'd3);
    check("prel_exit", 128'(exit_code_o), 128'(2));
    check("prel_eoc", 128'(eoc_o), 128'(1));

    // Boot 3 runs regardless of preload; reset after 6 words.
    start_run(2'd3, 2'd3);
    check("b3_ready", 128'(res_ready_o), 128'(1));
    check("b3_exit", 128'(exit_code_o), 128'(0));
    for (int i = 0; i < 6; i++) begin
      res_valid_i = 1'b1;
      res_data_i  = 32'hA0 + 32'(i);
      step();
    end
    res_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("mid_rst_ready", 128'(res_ready_o), 128'(0));
    check("mid_rst_eoc", 128'(eoc_o), 128'(0));
    check("mid_rst_exit", 128'(exit_code_o), 128'(0));
    step();
    rst_i = 1'b0;
    wait_init();
    read_line(9'd0, d);
    check("mid_line0", d, INIT_EN ? 128'(0) : line_of(32'hA0, 0));
    read_line(9'd1, d);
    check("mid_line1_kept", d, INIT_EN ? 128'(0) : line_of(32'h1000, 4));

    // Run C: read-first collision on line 0 and ignored start in RUN.
    start_run(2'd2, 2'd1);
    stream(32'h2000, -1, 1'b1, INIT_EN ? 128'(0) : line_of(32'hA0, 0));
    check("c_eoc", 128'(eoc_o), 128'(1));
    check("c_exit", 128'(exit_code_o), 128'(0));
    read_line(9'd1, d);
    check("c_line1", d, line_of(32'h2000, 4));
    read_line(9'd255, d);
    check("c_line255", d, line_of(32'h2000, 1020));
    read_line(9'd511, d);
    check("c_line511", d, line_of(32'h2000, 2044));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
